// File: rtl/rv32i_types.sv
// rv32i_types: shared rename-stage constants and the free-list pointer type.
package rv32i_types;
   localparam int ARCH_REGS = 32;
   localparam int FL_DEPTH = 32;
   typedef logic [$clog2(FL_DEPTH):0] fl_ptr_t;
endpackage

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical registers with one-cycle flush recovery.
// Optional FREE_LIST_PERF_EN adds internal performance counters.
module free_list
   import rv32i_types::*;
#(
   parameter int PS_WIDTH = 6,
   parameter int NUM_PREGS = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                free_list_enqueue,
   input  logic [PS_WIDTH-1:0] rrf_pd,
   input  logic                dequeue,
   output logic [PS_WIDTH-1:0] free_pd,
   output logic                free_pd_valid,
   input  logic                jump_commit,
   output logic                full,
   output logic                overflow_err
);
   localparam int DEPTH = NUM_PREGS - ARCH_REGS;
   localparam int AW = $clog2(DEPTH);
   logic [PS_WIDTH-1:0] mem [DEPTH];
   logic [AW:0] head, tail, head_next, tail_next;
   logic do_enq, do_deq;
   assign full = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
   assign free_pd_valid = head != tail;
   assign free_pd = mem[head[AW-1:0]];
   assign do_enq = free_list_enqueue && !full;
   assign do_deq = dequeue && free_pd_valid && !jump_commit;
   assign tail_next = tail + (AW+1)'(do_enq);
   // Flush frees everything between the new tail and the old head: the in-flight allocations.
   assign head_next = jump_commit ? {~tail_next[AW], tail_next[AW-1:0]} : head + (AW+1)'(do_deq);
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= PS_WIDTH'(ARCH_REGS + i);
         head <= '0;
         tail <= (AW+1)'(DEPTH);
         overflow_err <= 1'b0;
      end else begin
         if (do_enq) mem[tail[AW-1:0]] <= rrf_pd;
         head <= head_next;
         tail <= tail_next;
         if (free_list_enqueue && full) overflow_err <= 1'b1;
      end
   end
`ifdef FREE_LIST_PERF_EN
   logic [31:0] empty_stall_hk, min_count_hk, flush_count_hk;
   logic [AW:0] count;
   assign count = tail - head;
   always_ff @(posedge clk) begin
      if (!rst) begin
         empty_stall_hk <= '0;
         min_count_hk <= 32'(DEPTH);
         flush_count_hk <= '0;
      end else begin
         if (dequeue && !free_pd_valid) empty_stall_hk <= empty_stall_hk + 32'd1;
         if (32'(count) < min_count_hk) min_count_hk <= 32'(count);
         if (jump_commit) flush_count_hk <= flush_count_hk + 32'd1;
      end
   end
`else
   // counters absent; datapath unchanged
`endif
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: randomized and directed checks of free_list against a queue-based model.
module tb_free_list;
   logic clk = 1'b0, rst = 1'b0, free_list_enqueue = 1'b0, dequeue = 1'b0, jump_commit = 1'b0;
   logic [5:0] rrf_pd = '0, free_pd;
   logic free_pd_valid, full, overflow_err;
   int pass_cnt = 0, tot_cnt = 0;
   int fq[$], hq[$];
   bit movf;
   always #5 clk = ~clk;
   free_list dut (
      .clk(clk), .rst(rst), .free_list_enqueue(free_list_enqueue), .rrf_pd(rrf_pd),
      .dequeue(dequeue), .free_pd(free_pd), .free_pd_valid(free_pd_valid),
      .jump_commit(jump_commit), .full(full), .overflow_err(overflow_err)
   );
   task automatic check(input string tag, input int got, input int exp);
      tot_cnt++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask
   task automatic model_reset();
      fq.delete();
      hq.delete();
      for (int i = 0; i < 32; i++) fq.push_back(32 + i);
      movf = 0;
   endtask
   // Free set = returned registers in order; a flush prepends the most recent uncommitted allocations.
   task automatic cyc(input bit r, input bit d, input bit e, input int p, input bit j);
      bit deq_ok, was_full;
      int n;
      check("valid", free_pd_valid, fq.size() > 0);
      if (fq.size() > 0) check("free_pd", free_pd, fq[0]);
      check("full", full, fq.size() == 32);
      check("ovf", overflow_err, movf);
      rst = r; dequeue = d; free_list_enqueue = e; rrf_pd = 6'(p); jump_commit = j;
      @(posedge clk);
      if (!r) model_reset();
      else begin
         deq_ok = d && !j && fq.size() > 0;
         was_full = fq.size() == 32;
         if (deq_ok) begin
            hq.push_back(fq.pop_front());
            if (hq.size() > 32) void'(hq.pop_front());
         end
         if (e) begin
            if (was_full) movf = 1;
            else fq.push_back(p);
         end
         if (j) begin
            n = 32 - fq.size();
            if (n > hq.size()) n = hq.size();
            for (int k = 0; k < n; k++) fq.push_front(hq[hq.size() - 1 - k]);
         end
      end
      @(negedge clk);
      rst = 1'b1; dequeue = 1'b0; free_list_enqueue = 1'b0; jump_commit = 1'b0;
   endtask
   task automatic do_reset();
      cyc(0, 0, 0, 0, 0);
   endtask
   initial begin
      model_reset();
      @(negedge clk);
      check("rst_pd", free_pd, 32);
      check("rst_valid", free_pd_valid, 1);
      check("rst_full", full, 1);
      check("rst_ovf", overflow_err, 0);
      rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
         check("drain_seq", free_pd, 32 + i);
         cyc(1, 1, 0, 0, 0);
      end
      check("empty_valid", free_pd_valid, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 1, 5, 0);
      check("enq_empty_valid", free_pd_valid, 1);
      check("enq_empty_pd", free_pd, 5);
      check("enq_empty_full", full, 0);
      do_reset();
      for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0);
      for (int i = 1; i <= 4; i++) cyc(1, 0, 1, i, 0);
      cyc(1, 0, 0, 0, 1);
      check("flush_full", full, 1);
      for (int i = 0; i < 32; i++) begin
         check("flush_seq", free_pd, i < 28 ? 36 + i : i - 27);
         cyc(1, 1, 0, 0, 0);
      end
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 1, 7, 1);
      check("flush_enq_full", full, 1);
      for (int i = 0; i < 32; i++) begin
         check("flush_enq_seq", free_pd, i < 31 ? 33 + i : 7);
         cyc(1, 1, 0, 0, 0);
      end
      do_reset();
      cyc(1, 0, 1, 9, 0);
      check("ovf_set", overflow_err, 1);
      for (int i = 0; i < 32; i++) begin
         check("ovf_seq", free_pd, 32 + i);
         cyc(1, 1, 0, 0, 0);
      end
      check("ovf_sticky", overflow_err, 1);
      do_reset();
      cyc(1, 1, 0, 0, 0);
      for (int i = 0; i < 100; i++) begin
         check("wrap_full", full, 0);
         cyc(1, 1, 1, fq[0], 0);
      end
      check("wrap_count", fq.size(), 31);
      for (int i = 0; i < 800; i++)
         cyc($urandom_range(99) != 0, $urandom_range(9) < 6, $urandom_range(1) == 1,
             $urandom_range(63), $urandom_range(19) == 0);
      do_reset();
      check("final_pd", free_pd, 32);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
